// File: rtl/rom_word_writer_if.sv
// Loader handshake and ROM write-port bundle for rom_word_writer.
// Read-back signals exist only when ROM_WORD_WRITER_VERIFY_EN is defined.
interface rom_word_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
);
    // Loader: word offered while rom_loader_load=1; rom_loader_load_received pulses
    // once per word taken. ROM: rom_we (and rom_re) held until rom_ready=1.
    logic                  rom_loader_reset;
    logic                  rom_loader_load;
    logic [DATA_WIDTH-1:0] rom_loader_data;
    logic                  rom_loader_load_received;
    logic                  rom_loader_ack;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_wdata;
    logic                  rom_we;
    logic                  rom_ready;
`ifdef ROM_WORD_WRITER_VERIFY_EN
    logic                  rom_re;
    logic [DATA_WIDTH-1:0] rom_rdata;

    modport master (
        output rom_loader_reset, rom_loader_load, rom_loader_data, rom_ready, rom_rdata,
        input  rom_loader_load_received, rom_loader_ack, rom_addr, rom_wdata, rom_we, rom_re
    );
    modport slave (
        input  rom_loader_reset, rom_loader_load, rom_loader_data, rom_ready, rom_rdata,
        output rom_loader_load_received, rom_loader_ack, rom_addr, rom_wdata, rom_we, rom_re
    );
`else
    modport master (
        output rom_loader_reset, rom_loader_load, rom_loader_data, rom_ready,
        input  rom_loader_load_received, rom_loader_ack, rom_addr, rom_wdata, rom_we
    );
    modport slave (
        input  rom_loader_reset, rom_loader_load, rom_loader_data, rom_ready,
        output rom_loader_load_received, rom_loader_ack, rom_addr, rom_wdata, rom_we
    );
`endif
endinterface

// File: rtl/rom_word_writer.sv
// Writes words from the ROM feeder sequentially into the Hack ROM from address 0.
// Define ROM_WORD_WRITER_VERIFY_EN to add a read-back compare after every write.
module rom_word_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15,
    parameter int MAX_WORDS  = 32768
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rom_word_writer_if.slave      bus,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  overflow,
`ifdef ROM_WORD_WRITER_VERIFY_EN
    output logic                  verify_error,
`endif
    output logic [1:0]            fsm_state
);
    typedef enum logic [1:0] {IDLE, WRITE, VERIFY_RD, VERIFY_CMP} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH + 1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    logic                  load_received;
    logic                  rom_we;
    logic [DATA_WIDTH-1:0] rom_wdata;
`ifdef ROM_WORD_WRITER_VERIFY_EN
    logic                  rom_re;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            load_received <= 1'b0;
            rom_we        <= 1'b0;
            rom_wdata     <= '0;
            words_written <= '0;
            overflow      <= 1'b0;
`ifdef ROM_WORD_WRITER_VERIFY_EN
            rom_re        <= 1'b0;
            verify_error  <= 1'b0;
`endif
        end else if (bus.rom_loader_reset) begin
            state         <= IDLE;
            load_received <= 1'b0;
            rom_we        <= 1'b0;
            words_written <= '0;
            overflow      <= 1'b0;
`ifdef ROM_WORD_WRITER_VERIFY_EN
            rom_re        <= 1'b0;
            verify_error  <= 1'b0;
`endif
        end else begin
            load_received <= 1'b0;
            case (state)
                IDLE: begin
                    // The feeder still shows the old word while load_received is high.
                    if (bus.rom_loader_load && !load_received) begin
                        load_received <= 1'b1;
                        if (words_written < MAX_CNT) begin
                            rom_wdata <= bus.rom_loader_data;
                            rom_we    <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.rom_ready) begin
                        rom_we <= 1'b0;
`ifdef ROM_WORD_WRITER_VERIFY_EN
                        rom_re <= 1'b1;
                        state  <= VERIFY_RD;
`else
                        words_written <= words_written + ONE;
                        state         <= IDLE;
`endif
                    end
                end
`ifdef ROM_WORD_WRITER_VERIFY_EN
                VERIFY_RD: begin
                    if (bus.rom_ready) begin
                        rom_re <= 1'b0;
                        state  <= VERIFY_CMP;
                    end
                end
                VERIFY_CMP: begin
                    if (bus.rom_rdata != rom_wdata) verify_error <= 1'b1;
                    words_written <= words_written + ONE;
                    state         <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_loader_load_received = load_received;
    assign bus.rom_loader_ack           = (state == IDLE) && !bus.rom_loader_load;
    assign bus.rom_addr                 = words_written[ADDR_WIDTH-1:0];
    assign bus.rom_wdata                = rom_wdata;
    assign bus.rom_we                   = rom_we;
`ifdef ROM_WORD_WRITER_VERIFY_EN
    assign bus.rom_re                   = rom_re;
`endif
    assign fsm_state                    = state;
endmodule

// File: tb/tb_rom_word_writer.sv
// Directed bench for rom_word_writer: feeder driver, ROM model with a
// configurable ready delay, and a scoreboard of expected {addr, data} ROM writes.
module tb_rom_word_writer;
  localparam int DW   = 16;
  localparam int AW   = 15;
  localparam int MAXW = 4;
  localparam int EW   = AW + DW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rom_word_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [AW:0] words_written;
  logic        overflow;
  logic [1:0]  fsm_state;
  logic        rom_re_w;
`ifdef ROM_WORD_WRITER_VERIFY_EN
  logic        verify_error;
`endif

  rom_word_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus.slave),
    .words_written (words_written),
    .overflow      (overflow),
`ifdef ROM_WORD_WRITER_VERIFY_EN
    .verify_error  (verify_error),
`endif
    .fsm_state     (fsm_state)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int sent = 0;
  int lr_count = 0;
  int we_run = 0;
  int we_max = 0;
  int ready_delay = 0;
  int busy_cnt = 0;
  bit corrupt = 1'b0;
  logic prev_lr = 1'b0;
  logic [DW-1:0] mem [16];

`ifdef ROM_WORD_WRITER_VERIFY_EN
  assign rom_re_w = bus.rom_re;
  assign bus.rom_rdata = (corrupt && bus.rom_addr == 15'd2) ? 16'hDEAD : mem[bus.rom_addr[3:0]];
`else
  assign rom_re_w = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ROM side: ready tied high when delay is 0, else asserted after delay busy cycles.
  initial begin
    bus.rom_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_delay == 0) begin
        bus.rom_ready = 1'b1;
      end else if (bus.rom_we || rom_re_w) begin
        bus.rom_ready = (busy_cnt >= ready_delay);
        busy_cnt++;
      end else begin
        bus.rom_ready = 1'b0;
        busy_cnt = 0;
      end
    end
  end

  // Compare process: every cycle out of reset, check outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_lr = 1'b0;
        we_run = 0;
      end else begin
        if (bus.rom_we) begin
          check("write_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("write_addr_data", 32'({bus.rom_addr, bus.rom_wdata}), 32'(exp_q[0]));
          check("ack_low_in_write", 32'(bus.rom_loader_ack), 32'd0);
          we_run++;
          if (we_run > we_max) we_max = we_run;
        end else begin
          we_run = 0;
        end
        if (bus.rom_loader_load_received) begin
          lr_count++;
          check("lr_single_pulse", 32'(prev_lr), 32'd0);
        end
        prev_lr = bus.rom_loader_load_received;
        if (bus.rom_we && bus.rom_ready && !bus.rom_loader_reset) begin
          mem[bus.rom_addr[3:0]] = bus.rom_wdata;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Model: the n-th word since restart goes to address n, or is dropped past MAXW.
  task automatic present(input logic [DW-1:0] d);
    bus.rom_loader_load = 1'b1;
    bus.rom_loader_data = d;
    if (sent < MAXW) exp_q.push_back({AW'(sent), d});
    sent++;
  endtask

  task automatic wait_lr(input bit last);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rom_loader_load_received && n < 100);
    check("load_received_seen", 32'(bus.rom_loader_load_received), 32'd1);
    @(posedge clk);
    #1;
    if (last) bus.rom_loader_load = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] d, input bit last);
    present(d);
    wait_lr(last);
  endtask

  task automatic settle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.rom_we || !bus.rom_loader_ack) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_in_budget", 32'(n < 100), 32'd1);
    check("model_words_written", 32'(words_written), 32'((sent < MAXW) ? sent : MAXW));
    check("model_overflow", 32'(overflow), 32'(sent > MAXW));
    check("ack_idle", 32'(bus.rom_loader_ack), 32'd1);
  endtask

  task automatic restart();
    @(posedge clk);
    #1;
    bus.rom_loader_reset = 1'b1;
    bus.rom_loader_load = 1'b0;
    @(posedge clk);
    #1;
    bus.rom_loader_reset = 1'b0;
    exp_q.delete();
    sent = 0;
    lr_count = 0;
    we_max = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rom_loader_reset = 1'b0;
    bus.rom_loader_load = 1'b0;
    bus.rom_loader_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_load_received", 32'(bus.rom_loader_load_received), 32'd0);
    check("rst_ack", 32'(bus.rom_loader_ack), 32'd1);
    check("rst_rom_we", 32'(bus.rom_we), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_rom_wdata", 32'(bus.rom_wdata), 32'd0);
    check("rst_words_written", 32'(words_written), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    // Two words, ready tied high.
    ready_delay = 0;
    restart();
    feed(16'h1234, 1'b0);
    feed(16'hABCD, 1'b1);
    settle();
    check("t1_mem0", 32'(mem[0]), 32'h1234);
    check("t1_mem1", 32'(mem[1]), 32'hABCD);
    check("t1_words_written", 32'(words_written), 32'd2);
    check("t1_lr_pulses", 32'(lr_count), 32'd2);

    // ROM stalls five cycles on one word.
    restart();
    ready_delay = 5;
    feed(16'h00FF, 1'b1);
    settle();
    check("t2_we_cycles", 32'(we_max), 32'd6);
    check("t2_lr_pulses", 32'(lr_count), 32'd1);
    check("t2_mem0", 32'(mem[0]), 32'h00FF);
    ready_delay = 0;

    // Five words into a four-word ROM: last one is discarded.
    restart();
    for (int i = 0; i < 5; i++) feed(16'hA000 + 16'(i), i == 4);
    settle();
    check("t3_words_written", 32'(words_written), 32'd4);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_lr_pulses", 32'(lr_count), 32'd5);
    check("t3_mem3", 32'(mem[3]), 32'hA003);

    // Loader restart while word 3 is stuck in WRITE.
    restart();
    for (int i = 0; i < 3; i++) feed(16'hC000 + 16'(i), 1'b0);
    ready_delay = 30;
    feed(16'hC003, 1'b1);
    @(negedge clk);
    check("t4_we_pending", 32'(bus.rom_we), 32'd1);
    check("t4_addr_pending", 32'(bus.rom_addr), 32'd3);
    @(posedge clk);
    #1;
    bus.rom_loader_reset = 1'b1;
    bus.rom_loader_load = 1'b1;
    bus.rom_loader_data = 16'h5555;
    @(posedge clk);
    #1;
    bus.rom_loader_reset = 1'b0;
    exp_q.delete();
    sent = 0;
    ready_delay = 0;
    check("t4_we_dropped", 32'(bus.rom_we), 32'd0);
    check("t4_ww_cleared", 32'(words_written), 32'd0);
    check("t4_lr_ignored", 32'(bus.rom_loader_load_received), 32'd0);
    check("t4_addr_zero", 32'(bus.rom_addr), 32'd0);
    present(16'h5555);
    wait_lr(1'b1);
    settle();
    check("t4_mem0", 32'(mem[0]), 32'h5555);
    check("t4_words_written", 32'(words_written), 32'd1);

    // Asynchronous reset in the middle of a stalled write.
    restart();
    ready_delay = 30;
    feed(16'h00AA, 1'b1);
    @(negedge clk);
    check("t5_we_pending", 32'(bus.rom_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_we_async", 32'(bus.rom_we), 32'd0);
    check("t5_ww_async", 32'(words_written), 32'd0);
    check("t5_wdata_async", 32'(bus.rom_wdata), 32'd0);
    check("t5_ack_async", 32'(bus.rom_loader_ack), 32'd1);
    exp_q.delete();
    sent = 0;
    ready_delay = 0;
    #13;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_we_glitch", 32'(bus.rom_we), 32'd0);
    end

    // Back-to-back after async reset: addresses restart at 0.
    feed(16'h0101, 1'b0);
    feed(16'h0202, 1'b1);
    settle();
    check("t6_mem1", 32'(mem[1]), 32'h0202);

`ifdef ROM_WORD_WRITER_VERIFY_EN
    // Read-back of address 2 is corrupted by the ROM model.
    restart();
    check("tv_verify_clear", 32'(verify_error), 32'd0);
    corrupt = 1'b1;
    feed(16'h1111, 1'b0);
    feed(16'h2222, 1'b0);
    feed(16'hBEEF, 1'b0);
    feed(16'h4444, 1'b1);
    settle();
    check("tv_verify_error", 32'(verify_error), 32'd1);
    check("tv_words_written", 32'(words_written), 32'd4);
    corrupt = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
